param_sync_fifo: RTL and testbench



---
 rtl/param_sync_fifo.sv | 116 +++++++++++
 tb/tb_param_sync_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with self-managed pointers, occupancy count,
// full/empty/almost flags, sticky overflow/underflow errors and a synchronous
// flush. Reads are registered: DataOut/DataValid appear one cycle after an
// accepted Read, and a word written in cycle N is first readable in cycle N+1.
module param_sync_fifo #(
  parameter int WIDTH    = 9,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Clear,
  input  logic                     Write,
  input  logic [WIDTH-1:0]         DataIn,
  input  logic                     Read,
  output logic [WIDTH-1:0]         DataOut,
  output logic                     DataValid,
  output logic                     Full,
  output logic                     Empty,
  output logic                     AlmostFull,
  output logic                     AlmostEmpty,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  output logic                     Underflow
);

  localparam int AW = $clog2(DEPTH);

  // Thresholds sized to the count so flag compares are width-matched.
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_L    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_L    = (AW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_rd_ok;
  logic             w_wr_ok;

  // Flags are pure functions of the occupancy count.
  always_comb begin
    w_full      = (r_count == DEPTH_L);
    w_empty     = (r_count == '0);
    // A read on a full FIFO frees the slot the simultaneous write will use.
    w_rd_ok     = Read & ~w_empty;
    w_wr_ok     = Write & (~w_full | w_rd_ok);
  end

  // Storage array; deliberately not reset, and untouched by Clear.
  always_ff @(posedge Clk) begin
    if (w_wr_ok && !Clear) begin
      r_mem[r_wptr] <= DataIn;
    end
  end

  // Pointers, count, read data and sticky error state; Clear beats Write/Read.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (Clear) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_data_valid <= w_rd_ok;
      if (w_rd_ok) begin
        // Nonblocking read sees the old word even if the write hits this slot.
        r_data_out <= r_mem[r_rptr];
        r_rptr     <= r_rptr + 1'b1;
      end
      if (w_wr_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (Write && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
      if (Read && !w_rd_ok) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign DataOut     = r_data_out;
  assign DataValid   = r_data_valid;
  assign Count       = r_count;
  assign Full        = w_full;
  assign Empty       = w_empty;
  assign AlmostFull  = (r_count >= AF_L);
  assign AlmostEmpty = (r_count <= AE_L);
  assign Overflow    = r_overflow;
  assign Underflow   = r_underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_param_sync_fifo;

  localparam int WIDTH    = 9;
  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = 6;
  localparam int AE_LEVEL = 2;
  localparam int AW       = $clog2(DEPTH);

  logic             Clk;
  logic             Rst_n;
  logic             Clear;
  logic             Write;
  logic [WIDTH-1:0] DataIn;
  logic             Read;
  logic [WIDTH-1:0] DataOut;
  logic             DataValid;
  logic             Full;
  logic             Empty;
  logic             AlmostFull;
  logic             AlmostEmpty;
  logic [AW:0]      Count;
  logic             Overflow;
  logic             Underflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_out;
  logic             m_valid;
  logic             m_ovf;
  logic             m_udf;

  param_sync_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Clear(Clear), .Write(Write), .DataIn(DataIn),
    .Read(Read), .DataOut(DataOut), .DataValid(DataValid), .Full(Full),
    .Empty(Empty), .AlmostFull(AlmostFull), .AlmostEmpty(AlmostEmpty),
    .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // One clock of FIFO behaviour expressed on a queue.
  task automatic model_update(input logic w, input logic [WIDTH-1:0] d,
                              input logic r, input logic c);
    bit rd_ok;
    bit wr_ok;
    if (c) begin
      m_q.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      rd_ok = r && (m_q.size() > 0);
      wr_ok = w && ((m_q.size() < DEPTH) || rd_ok);
      m_valid = rd_ok;
      if (rd_ok) m_out = m_q.pop_front();
      if (wr_ok) m_q.push_back(d);
      if (w && !wr_ok) m_ovf = 1'b1;
      if (r && !rd_ok) m_udf = 1'b1;
    end
  endtask

  task automatic check_all(input string pfx);
    int n;
    n = m_q.size();
    check({pfx, ".count"},  32'(Count),       32'(n));
    check({pfx, ".empty"},  32'(Empty),       32'(n == 0));
    check({pfx, ".full"},   32'(Full),        32'(n == DEPTH));
    check({pfx, ".afull"},  32'(AlmostFull),  32'(n >= AF_LEVEL));
    check({pfx, ".aempty"}, 32'(AlmostEmpty), 32'(n <= AE_LEVEL));
    check({pfx, ".ovf"},    32'(Overflow),    32'(m_ovf));
    check({pfx, ".udf"},    32'(Underflow),   32'(m_udf));
    check({pfx, ".valid"},  32'(DataValid),   32'(m_valid));
    check({pfx, ".dout"},   32'(DataOut),     32'(m_out));
  endtask

  // Drive one cycle of inputs (called just after a falling edge), then check
  // outputs at the next falling edge.
  task automatic step(input logic w, input logic [WIDTH-1:0] d,
                      input logic r, input logic c, input string pfx);
    Write  = w;
    DataIn = d;
    Read   = r;
    Clear  = c;
    @(posedge Clk);
    model_update(w, d, r, c);
    @(negedge Clk);
    Write = 1'b0;
    Read  = 1'b0;
    Clear = 1'b0;
    check_all(pfx);
  endtask

  // Reset asserted mid-cycle, away from any clock edge.
  task automatic async_reset(input string pfx);
    Write = 1'b0;
    Read  = 1'b0;
    Clear = 1'b0;
    #2;
    Rst_n = 1'b0;
    #1;
    model_reset();
    check_all(pfx);
    @(negedge Clk);
    Rst_n = 1'b1;
    check_all({pfx, ".rel"});
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    bit w;
    bit r;
    bit c;
    int wr_pct;

    Rst_n  = 1'b0;
    Clear  = 1'b0;
    Write  = 1'b0;
    Read   = 1'b0;
    DataIn = '0;
    model_reset();
    repeat (3) @(negedge Clk);
    check_all("reset");
    Rst_n = 1'b1;
    step(0, '0, 0, 0, "idle");

    // Read on empty: underflow, count stays 0.
    step(0, '0, 1, 0, "udf");
    step(0, '0, 0, 1, "clr0");

    // Fill with 1..8, then one rejected write.
    for (int i = 1; i <= DEPTH; i++) step(1, WIDTH'(i), 0, 0, "fill");
    step(1, 9'h1FF, 0, 0, "ovf");

    // Drain: data must be 1..8 (memory untouched by the rejected write).
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 0, "drain");
    step(0, '0, 0, 1, "clr1");

    // Pointer wrap-around.
    for (int i = 0; i < 5; i++) step(1, WIDTH'(9'h050 + i), 0, 0, "wr5");
    for (int i = 0; i < 5; i++) step(0, '0, 1, 0, "rd5");
    for (int i = 0; i < 6; i++) step(1, WIDTH'(9'h0AA + i), 0, 0, "wrap_wr");
    for (int i = 0; i < 6; i++) step(0, '0, 1, 0, "wrap_rd");

    // Simultaneous read+write when full and when empty.
    for (int i = 0; i < DEPTH; i++) step(1, WIDTH'(9'h100 + i), 0, 0, "fill2");
    step(1, 9'h155, 1, 0, "rw_full");
    step(1, 9'h156, 1, 0, "rw_full2");
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 0, "drain2");
    step(1, 9'h0C3, 1, 0, "rw_empty");
    step(0, '0, 1, 0, "rd_last");

    // Clear together with Write at count 5 with overflow set.
    step(0, '0, 0, 1, "clr2");
    for (int i = 0; i < DEPTH; i++) step(1, WIDTH'(9'h020 + i), 0, 0, "fill3");
    step(1, 9'h1EE, 0, 0, "ovf2");
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, "rd3");
    step(1, 9'h077, 0, 1, "clr_wr");
    step(0, '0, 0, 0, "after_clr");

    // Reset in the middle of a burst with a read in flight.
    for (int i = 0; i < 4; i++) step(1, WIDTH'(9'h033 + i), 0, 0, "burst");
    step(1, 9'h040, 1, 0, "burst_rw");
    async_reset("arst");

    // Randomized traffic with alternating fill/drain bias.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      wr_pct = ((cyc / 150) % 2 == 0) ? 75 : 25;
      w = ($urandom_range(99) < wr_pct);
      r = ($urandom_range(99) < (100 - wr_pct));
      c = ($urandom_range(199) == 0);
      d = WIDTH'($urandom);
      if ($urandom_range(799) == 0) async_reset("rnd_arst");
      else step(w, d, r, c, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
